// File: rtl/image_pkg.sv
// Shared image-side definitions: loader FSM states, 12-bit RGB pixel type
// and the default high-byte marker nibble.
package image_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef logic [11:0] pixel_t;

    localparam logic [3:0] MARKER_DEFAULT = 4'hA;

endpackage

// File: rtl/image_loader_pixel_packer.sv
// Pairs high/low bytes into a 12-bit pixel: validates the high-byte marker,
// latches its nibble, and strobes a pixel when the low byte is accepted.
import image_pkg::*;

module pixel_packer #(
    parameter logic [3:0] MARKER = MARKER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       accept,
    input  logic       phase_lo,
    input  logic [7:0] byte_data,
    output logic       hi_ok,
    output logic       hi_bad,
    output logic       pix_valid,
    output pixel_t     pix_data
);

    logic [3:0] nibble_reg;
    logic       marker_match;

    assign marker_match = (byte_data[7:4] == MARKER);

    // A restart takes priority over any byte accepted in the same cycle.
    assign hi_ok     = accept && !phase_lo &&  marker_match && !clear;
    assign hi_bad    = accept && !phase_lo && !marker_match && !clear;
    assign pix_valid = accept &&  phase_lo && !clear;
    assign pix_data  = {nibble_reg, byte_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nibble_reg <= 4'd0;
        end else if (clear) begin
            nibble_reg <= 4'd0;
        end else if (hi_ok) begin
            nibble_reg <= byte_data[3:0];
        end
    end

endmodule

// File: rtl/image_loader.sv
// Loads a WIDTH x HEIGHT 12-bit image from a byte stream into the sprite BRAM
// write port, row-major from address 0.
import image_pkg::*;

module image_loader #(
    parameter int         WIDTH  = 256,
    parameter int         HEIGHT = 256,
    parameter logic [3:0] MARKER = MARKER_DEFAULT,
    localparam int        ADDR_W = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid_in,
    output logic              byte_ready_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [11:0]       bram_data_out,
    output logic              bram_we_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg;
    pixel_t            data_reg;
    logic              we_reg, busy_reg, done_reg, err_reg;
    logic              done_next;

    logic   accept;
    logic   hi_ok, hi_bad, pix_valid;
    pixel_t pix_data;

    assign byte_ready_out = (state_reg == HI) || (state_reg == LO);
    assign accept         = byte_valid_in && byte_ready_out;

    pixel_packer #(
        .MARKER(MARKER)
    ) u_packer (
        .clk       (pixel_clk_in),
        .rst_n     (rst_in),
        .clear     (start_in),
        .accept    (accept),
        .phase_lo  (state_reg == LO),
        .byte_data (byte_in),
        .hi_ok     (hi_ok),
        .hi_bad    (hi_bad),
        .pix_valid (pix_valid),
        .pix_data  (pix_data)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        if (start_in) begin
            state_next = HI;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: state_next = IDLE;
                HI: begin
                    if (hi_ok) begin
                        state_next = LO;
                    end
                end
                LO: begin
                    if (pix_valid) begin
                        if (cnt_reg == LAST_ADDR) begin
                            state_next = DONE;
                        end else begin
                            state_next = HI;
                            cnt_next   = cnt_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            we_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            we_reg    <= pix_valid;
            // Address/data hold their last written values between writes.
            if (pix_valid) begin
                addr_reg <= cnt_reg;
                data_reg <= pix_data;
            end
            busy_reg <= (state_next == HI) || (state_next == LO);
            done_reg <= done_next;
            err_reg  <= hi_bad;
        end
    end

    assign bram_addr_out = addr_reg;
    assign bram_data_out = data_reg;
    assign bram_we_out   = we_reg;
    assign busy_out      = busy_reg;
    assign done_out      = done_reg;
    assign error_out     = err_reg;

endmodule

// File: tb/tb_image_loader.sv
// Randomized and directed bench for image_loader (4x2 image) against a
// transaction-level model of the byte-pair protocol.
module tb_image_loader;

    localparam int W = 4;
    localparam int H = 2;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] byte_val = 8'd0;
    logic       valid = 1'b0;
    logic       ready;
    logic [2:0] addr;
    logic [11:0] data;
    logic       we, busy, done, err;

    int checks = 0;
    int errors = 0;

    // Model state: is a load running, which byte of the pair comes next,
    // pending nibble, pixel index, and whether the finishing cycle is underway.
    bit         m_active, m_want_hi, m_finishing;
    bit [3:0]   m_nib;
    int         m_count;
    bit         e_we, e_err, e_done, e_busy;
    int         e_addr, e_data;
    int         writes_seen;

    always #5 clk = ~clk;

    image_loader #(.WIDTH(W), .HEIGHT(H), .MARKER(4'hA)) dut (
        .pixel_clk_in   (clk),
        .rst_in         (rst_n),
        .start_in       (start),
        .byte_in        (byte_val),
        .byte_valid_in  (valid),
        .byte_ready_out (ready),
        .bram_addr_out  (addr),
        .bram_data_out  (data),
        .bram_we_out    (we),
        .busy_out       (busy),
        .done_out       (done),
        .error_out      (err)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_want_hi = 1; m_finishing = 0; m_nib = 0; m_count = 0;
        e_we = 0; e_err = 0; e_done = 0; e_busy = 0; e_addr = 0; e_data = 0;
    endtask

    task automatic compare_all();
        check_val("ready", int'(ready), int'(m_active));
        check_val("we",    int'(we),    int'(e_we));
        check_val("addr",  int'(addr),  e_addr);
        check_val("data",  int'(data),  e_data);
        check_val("busy",  int'(busy),  int'(e_busy));
        check_val("done",  int'(done),  int'(e_done));
        check_val("error", int'(err),   int'(e_err));
        if (we) writes_seen++;
        $display("cyc t=%0t start=%0b v=%0b byte=%02h we=%0b addr=%0d data=%03h done=%0b err=%0b",
                 $time, start, valid, byte_val, we, addr, data, done, err);
    endtask

    task automatic model_update(input bit s, input bit v, input bit [7:0] b);
        bit accepted;
        accepted = m_active && v;
        e_we = 0; e_err = 0; e_done = 0;
        if (m_finishing) begin
            m_finishing = 0;
            if (!s) e_done = 1;
        end
        if (s) begin
            m_active = 1; m_want_hi = 1; m_count = 0; m_nib = 0;
        end else if (accepted) begin
            if (m_want_hi) begin
                if (b[7:4] == 4'hA) begin
                    m_nib = b[3:0];
                    m_want_hi = 0;
                end else begin
                    e_err = 1;
                end
            end else begin
                e_we = 1;
                e_addr = m_count;
                e_data = {m_nib, b};
                m_want_hi = 1;
                if (m_count == NPIX - 1) begin
                    m_active = 0;
                    m_finishing = 1;
                end else begin
                    m_count++;
                end
            end
        end
        e_busy = m_active;
    endtask

    task automatic step(input bit s, input bit v, input bit [7:0] b);
        @(negedge clk);
        compare_all();
        start = s; valid = v; byte_val = b;
        model_update(s, v, b);
    endtask

    task automatic send_pixel(input bit [3:0] hi_nib, input bit [7:0] lo);
        step(0, 1, {4'hA, hi_nib});
        step(0, 1, lo);
    endtask

    initial begin
        model_reset();
        writes_seen = 0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: bytes are ignored before any start.
        step(0, 1, 8'hA1);
        step(0, 1, 8'h23);

        // Full 8-pixel load, valid held high; first pixel is 0x123.
        step(1, 0, 8'h00);
        for (int k = 0; k < NPIX; k++) send_pixel(4'(k + 1), 8'(8'h23 + k));
        for (int k = 0; k < 4; k++) step(0, 0, 8'h00);

        // Bad marker then a good pixel at the unchanged address.
        step(1, 0, 8'h00);
        step(0, 1, 8'h51);
        send_pixel(4'h4, 8'h56);

        // Gappy valid between high and low byte.
        step(0, 1, 8'hA7);
        for (int k = 0; k < 3; k++) step(0, 0, 8'h00);
        step(0, 1, 8'h89);

        // Restart after 3 pixels (already 2 written above, one more).
        send_pixel(4'h3, 8'h33);
        step(1, 0, 8'h00);
        send_pixel(4'hC, 8'hDE);

        // Start coincident with a low byte: that byte is dropped.
        step(0, 1, 8'hA1);
        step(1, 1, 8'h23);
        step(0, 1, 8'hA9);
        step(0, 1, 8'h87);

        // Asynchronous reset while in LO.
        step(0, 1, 8'hA5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_ready", int'(ready), 0);
        check_val("rst_we",    int'(we),    0);
        check_val("rst_addr",  int'(addr),  0);
        check_val("rst_data",  int'(data),  0);
        check_val("rst_busy",  int'(busy),  0);
        check_val("rst_done",  int'(done),  0);
        check_val("rst_error", int'(err),   0);
        @(negedge clk);
        rst_n = 1'b1; start = 0; valid = 0; byte_val = 0;
        step(0, 1, 8'hA6);
        step(0, 1, 8'h66);
        step(1, 0, 8'h00);
        send_pixel(4'hF, 8'h0F);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            bit s, v;
            bit [7:0] b;
            s = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 7);
            b = 8'($urandom);
            if ($urandom_range(0, 99) < 85) b[7:4] = 4'hA;
            step(s, v, b);
        end
        step(0, 0, 8'h00);
        check_val("writes_observed_nonzero", int'(writes_seen > 20), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_loader.md
# image_loader

Writes a WIDTH×HEIGHT 12-bit RGB image into the sprite BRAM's write port from an 8-bit byte stream, such as one delivered by the UART receiver. It is the write-side counterpart of the sprite read path, which fetches pixels at address (hcount−x) + (vcount−y)·WIDTH. The loader produces that same row-major addressing, starting at 0. It sits between the byte source and port A of the image BRAM; the sprite renderer reads port B.

## Interface
Parameters:
- WIDTH, 256, image width in pixels
- HEIGHT, 256, image height in pixels
- MARKER, 4'hA, required upper nibble of every high byte

Ports (ADDR_W = $clog2(WIDTH*HEIGHT)):
- pixel_clk_in  input  1  sole clock; everything is on its rising edge
- rst_in  input  1  asynchronous, active-low reset
- start_in  input  1  one-cycle pulse; begins or restarts a load at address 0
- byte_in  input  8  stream data
- byte_valid_in  input  1  byte_in is valid this cycle
- byte_ready_out  output  1  loader accepts a byte this cycle
- bram_addr_out  output  ADDR_W  BRAM write address
- bram_data_out  output  12  BRAM write data {R[3:0],G[3:0],B[3:0]}
- bram_we_out  output  1  BRAM write enable, one cycle per pixel
- busy_out  output  1  a load is in progress
- done_out  output  1  one-cycle pulse after the last pixel is written
- error_out  output  1  one-cycle pulse when a high byte is rejected

## Operation
- A byte is accepted when byte_valid_in and byte_ready_out are both high in the same cycle.
- Each pixel is two bytes:
  - High byte: bits [7:4] must equal MARKER; bits [3:0] → pixel[11:8].
  - Low byte: bits [7:0] → pixel[7:0].
- FSM states:
  - IDLE: byte_ready_out=0, busy_out=0. start_in → HI, pixel counter cleared to 0.
  - HI: byte_ready_out=1. An accepted byte with a good marker latches its nibble → LO. An accepted byte with a bad marker is discarded, error_out pulses, state stays HI.
  - LO: byte_ready_out=1. An accepted byte forms the pixel and issues the write. If the counter was WIDTH*HEIGHT−1 → DONE, else counter+1 → HI.
  - DONE: done_out=1 for exactly this one cycle → IDLE.
- start_in in HI, LO or DONE aborts the current load: the counter goes to 0, any latched nibble is dropped, the state becomes HI, and done_out is not pulsed. start_in has priority over a byte accepted in the same cycle; that byte is discarded.
- The counter is ADDR_W bits and never wraps. Reaching the last pixel always ends in DONE.
- Reset (asynchronous, any state): state IDLE, counter 0, latched nibble 0. All outputs 0: byte_ready_out, bram_addr_out, bram_data_out, bram_we_out, busy_out, done_out, error_out.
- busy_out = 1 in HI and LO.

## Timing
- All outputs are registered except byte_ready_out, which is decoded from the state (HI or LO).
- When a low byte is accepted at edge N, bram_we_out, bram_addr_out and bram_data_out are valid in the cycle after edge N. bram_we_out is high for one cycle only.
- bram_addr_out and bram_data_out hold their last values while bram_we_out=0.
- Throughput: one byte per cycle, i.e. one pixel per two cycles when byte_valid_in is held high.
- done_out is asserted in the cycle after the last write cycle.
- error_out is asserted in the cycle after the bad byte is accepted.
- A start_in pulse at edge N puts the loader in HI at N, so byte_ready_out=1 in the following cycle.

## Structure
- Package image_pkg holds:
  - the state enum typedef (IDLE, HI, LO, DONE)
  - the 12-bit pixel_t typedef
  - the MARKER default constant
- image_pkg is shared with image-side display blocks.
- A single sub-module, pixel_packer, is natural. It combines the high/low byte handshake and nibble latch and exposes a pixel valid strobe plus 12-bit data.
- image_loader keeps the FSM, the counter and the BRAM port registers.

## Test plan
- WIDTH=4, HEIGHT=2, start, bytes A1,23 … for 8 pixels with valid held high → 8 writes at addresses 0..7, the first being data 0x123. done_out pulses once, the cycle after the write to address 7. busy_out then drops.
- Bad marker: in HI send 0x51 → no write, error_out pulses. Then A4,56 → write 0x456 at the current address, counter unchanged by the rejected byte.
- Gappy valid: valid low for 3 cycles between the high and low bytes → byte_ready_out stays 1 and the pixel data is still correct.
- start_in mid-load after 3 pixels → the next write goes to address 0 and done_out does not pulse for the aborted load.
- rst_in low during LO → all outputs 0 immediately (asynchronous). After release, bytes are ignored until start_in; a load then begins at address 0.
- start_in coincident with an accepted low byte → no write; the next accepted byte is treated as a high byte.
